// File: rtl/remote_comm_if.sv
// Host-side command/response bundle for remote_comm.
// master = host logic issuing commands, slave = remote_comm.
interface remote_comm_if;
  logic        snd_cmd;
  logic [15:0] cmd;
  logic [7:0]  resp;
  logic        cmd_snt;
  logic        resp_rdy;

  modport master (
    output snd_cmd, cmd,
    input  resp, cmd_snt, resp_rdy
  );

  modport slave (
    input  snd_cmd, cmd,
    output resp, cmd_snt, resp_rdy
  );
endinterface

// File: rtl/remote_comm.sv
// Host-side UART link: 16-bit command out as two 8N1 frames, 1-byte reply in.
// Optional REMOTE_COMM_RX_SYNC_EN adds a 2-flop RX synchronizer.
module remote_comm #(
  parameter int BAUD_DIV = 2604
) (
  input  logic          clk,
  input  logic          rst,
  remote_comm_if.slave  host,
  input  logic          RX,
  output logic          TX
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {
    T_IDLE, T_HIGH, T_LOW
  } tx_st_t;

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_st_t;

  tx_st_t        tst, tst_nx;
  logic [15:0]   hold;
  logic [CW-1:0] tcnt;
  logic [3:0]    tbit;
  logic          tx_last;
  logic          accept;
  logic          tx_nx;
  logic [7:0]    byte_sel;
  logic [9:0]    frame;
  logic          done_q;
  logic          cmd_snt_q;

  rx_st_t        rst_st, rst_nx;
  logic          rx_s;
  logic          rx_prev;
  logic [CW-1:0] rcnt;
  logic [2:0]    rbit;
  logic [7:0]    rsh;
  logic [7:0]    resp_q;
  logic          resp_rdy_q;
  logic          rx_fall;
  logic          rx_start_ok;
  logic          rx_shift;
  logic          rx_load;

  assign tx_last = (tcnt == LAST) && (tbit == 4'd9);
  assign accept  = host.snd_cmd && (tst == T_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tst <= T_IDLE;
    else     tst <= tst_nx;
  end

  always_comb begin
    tst_nx = tst;
    unique case (tst)
      T_IDLE:  if (host.snd_cmd) tst_nx = T_HIGH;
      T_HIGH:  if (tx_last) tst_nx = T_LOW;
      T_LOW:   if (tx_last) tst_nx = T_IDLE;
      default: tst_nx = T_IDLE;
    endcase
  end

  // TX is registered, so the start bit appears one edge after acceptance
  always_comb begin
    byte_sel = (tst == T_LOW) ? hold[7:0] : hold[15:8];
    frame    = {1'b1, byte_sel, 1'b0};
    tx_nx    = 1'b1;
    if (tst != T_IDLE) tx_nx = frame[tbit];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
      tbit <= '0;
    end else if (tst == T_IDLE) begin
      tcnt <= '0;
      tbit <= '0;
    end else if (tcnt == LAST) begin
      tcnt <= '0;
      tbit <= (tbit == 4'd9) ? 4'd0 : tbit + 4'd1;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      TX        <= 1'b1;
      hold      <= '0;
      done_q    <= 1'b0;
      cmd_snt_q <= 1'b0;
    end else begin
      TX     <= tx_nx;
      done_q <= (tst == T_LOW) && tx_last;
      if (accept) hold <= host.cmd;
      if (accept)      cmd_snt_q <= 1'b0;
      else if (done_q) cmd_snt_q <= 1'b1;
    end
  end

`ifdef REMOTE_COMM_RX_SYNC_EN
  logic [1:0] rx_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_sync <= 2'b11;
    else     rx_sync <= {rx_sync[0], RX};
  end

  assign rx_s = rx_sync[1];
`else
  assign rx_s = RX;
`endif

  assign rx_fall = rx_prev && !rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_st <= R_IDLE;
    else     rst_st <= rst_nx;
  end

  always_comb begin
    rst_nx = rst_st;
    unique case (rst_st)
      R_IDLE:  if (rx_fall) rst_nx = R_START;
      R_START: if (rcnt == HALF) rst_nx = rx_s ? R_IDLE : R_DATA;
      R_DATA:  if (rcnt == LAST && rbit == 3'd7) rst_nx = R_STOP;
      R_STOP:  if (rcnt == LAST) rst_nx = R_IDLE;
      default: rst_nx = R_IDLE;
    endcase
  end

  always_comb begin
    rx_start_ok = (rst_st == R_START) && (rcnt == HALF) && !rx_s;
    rx_shift    = (rst_st == R_DATA) && (rcnt == LAST);
    rx_load     = (rst_st == R_STOP) && (rcnt == LAST);
  end

  // counter restarts on every state change so each phase times from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt <= '0;
      rbit <= '0;
    end else begin
      if (rst_nx != rst_st || rcnt == LAST) rcnt <= '0;
      else if (rst_st != R_IDLE)            rcnt <= rcnt + 1'b1;
      if (rst_st != R_DATA) rbit <= '0;
      else if (rx_shift)    rbit <= rbit + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_prev    <= 1'b1;
      rsh        <= '0;
      resp_q     <= '0;
      resp_rdy_q <= 1'b0;
    end else begin
      rx_prev <= rx_s;
      if (rx_shift) rsh <= {rx_s, rsh[7:1]};
      if (rx_load) resp_q <= rsh;
      if (rx_load)                        resp_rdy_q <= 1'b1;
      else if (accept || rx_start_ok)     resp_rdy_q <= 1'b0;
    end
  end

  assign host.resp     = resp_q;
  assign host.resp_rdy = resp_rdy_q;
  assign host.cmd_snt  = cmd_snt_q;

endmodule

// File: tb/tb_remote_comm.sv
// Scoreboard bench for remote_comm: frame-level TX monitor and RX reply monitor
// checked against an edge-count model of the command/response protocol.
`timescale 1ns/1ps
module tb_remote_comm;
  localparam int BD = 16;
  localparam int FR = 10 * BD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic RX  = 1'b1;
  logic TX;

  remote_comm_if bus();

  remote_comm #(.BAUD_DIV(BD)) dut (
    .clk  (clk),
    .rst  (rst),
    .host (bus.slave),
    .RX   (RX),
    .TX   (TX)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    int         start;
  } txe_t;

  txe_t       exp_tx[$];
  logic [7:0] exp_rsp[$];
  int checks   = 0;
  int failures = 0;
  int last_c0  = -100000;
  int rx_fall  = 0;
  int last_rise = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Model: a command is accepted only once the previous 20-bit-time
  // transfer has fully ended; high byte starts one edge after acceptance.
  task automatic send_cmd(input logic [15:0] c);
    int   e;
    txe_t t;
    @(negedge clk);
    bus.cmd     = c;
    bus.snd_cmd = 1'b1;
    e = cyc + 1;
    if (e > last_c0 + 2 * FR) begin
      last_c0 = e;
      t.b = c[15:8]; t.start = e + 1;      exp_tx.push_back(t);
      t.b = c[7:0];  t.start = e + 1 + FR; exp_tx.push_back(t);
    end
    @(negedge clk);
    bus.snd_cmd = 1'b0;
  endtask

  task automatic send_at(input int edge_n, input logic [15:0] c);
    while (cyc < edge_n - 2) @(negedge clk);
    send_cmd(c);
  endtask

  task automatic robot_tx(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    exp_rsp.push_back(b);
    @(negedge clk);
    rx_fall = cyc;
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      repeat (BD) @(negedge clk);
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((cyc <= last_c0 + 2 * FR + 2 || exp_tx.size() != 0 ||
            exp_rsp.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({"done_", name}, (n < 5000), 1);
  endtask

  // TX frame monitor
  initial begin
    int         ph;
    int         cnt;
    int         st;
    logic       txp;
    logic [9:0] sh;
    txe_t       e;
    ph = -1; cnt = 0; st = 0; txp = 1'b1; sh = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ph = -1;
      end else begin
        if (ph < 0 && txp && !TX) begin
          ph = 0; cnt = 0; st = cyc;
        end
        if (ph >= 0) begin
          if (cnt == BD / 2 + ph * BD) begin
            sh[ph] = TX;
            ph++;
            if (ph == 10) begin
              ph = -1;
              if (exp_tx.size() == 0) begin
                checks++; failures++;
                $display("FAIL tx_unexpected: got byte %0h want none", sh[8:1]);
              end else begin
                e = exp_tx.pop_front();
                chk("tx_byte", sh[8:1], e.b);
                chk("tx_start_cycle", st, e.start);
                chk("tx_framing", {sh[9], sh[0]}, 2'b10);
              end
            end
          end
          cnt++;
        end
      end
      txp = rst ? 1'b1 : TX;
    end
  end

  // response monitor
  initial begin
    logic p;
    p = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p = 1'b0;
      end else begin
        if (bus.resp_rdy && !p) begin
          last_rise = cyc;
          if (exp_rsp.size() == 0) begin
            checks++; failures++;
            $display("FAIL resp_unexpected: got %0h want none", bus.resp);
          end else begin
            chk("resp", bus.resp, exp_rsp.pop_front());
          end
        end
        p = bus.resp_rdy;
      end
    end
  end

  initial begin
    int c0;
    int lat;
    logic [15:0] rc;
    bus.snd_cmd = 1'b0;
    bus.cmd     = '0;

    repeat (3) @(negedge clk);
    chk("rst_tx", TX, 1);
    chk("rst_cmd_snt", bus.cmd_snt, 0);
    chk("rst_resp_rdy", bus.resp_rdy, 0);
    chk("rst_resp", bus.resp, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    send_cmd(16'h2000);
    c0 = last_c0;
    while (cyc < c0 + 2 * FR) @(negedge clk);
    chk("cmd_snt_early", bus.cmd_snt, 0);
    @(negedge clk);
    chk("cmd_snt_rise", bus.cmd_snt, 1);
    repeat (50) @(negedge clk);
    chk("cmd_snt_hold", bus.cmd_snt, 1);
    wait_done("2000");

    robot_tx(8'hA5);
    repeat (4) @(negedge clk);
    lat = last_rise - rx_fall;
    chk("rx_latency", (lat >= BD / 2 + 9 * BD && lat <= BD / 2 + 9 * BD + 4), 1);
    chk("loop_rdy", bus.resp_rdy, 1);
    chk("loop_resp", bus.resp, 8'hA5);
    send_cmd(16'h4001);
    c0 = last_c0;
    chk("clr_rdy", bus.resp_rdy, 0);
    chk("clr_snt", bus.cmd_snt, 0);
    send_at(c0 + 100, 16'hFFFF);
    send_at(c0 + 2 * FR, 16'($urandom));
    wait_done("4001");
    chk("snt_4001", bus.cmd_snt, 1);

    @(negedge clk);
    RX = 1'b0;
    repeat (BD / 4) @(negedge clk);
    RX = 1'b1;
    repeat (12 * BD) @(negedge clk);
    chk("glitch_rdy", bus.resp_rdy, 0);
    chk("glitch_resp", bus.resp, 8'hA5);

    fork
      send_cmd(16'($urandom));
      begin
        repeat ($urandom_range(0, 30)) @(negedge clk);
        robot_tx(8'h5A);
      end
    join
    wait_done("duplex");
    chk("duplex_resp", bus.resp, 8'h5A);

    for (int k = 0; k < 4; k++) begin
      rc = 16'($urandom);
      fork
        send_cmd(rc);
        begin
          repeat ($urandom_range(0, 200)) @(negedge clk);
          robot_tx(8'($urandom));
        end
      join
      wait_done("rand");
    end

    send_cmd({8'h3C, 8'($urandom)});
    c0 = last_c0;
    while (cyc < c0 + 39) @(negedge clk);
    chk("tx_pre_reset", TX, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", TX, 1);
    chk("mid_rst_snt", bus.cmd_snt, 0);
    chk("mid_rst_rdy", bus.resp_rdy, 0);
    chk("mid_rst_resp", bus.resp, 0);
    exp_tx.delete();
    last_c0 = -100000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_cmd(16'($urandom));
    wait_done("post_rst");
    chk("post_rst_snt", bus.cmd_snt, 1);

    chk("tx_queue_empty", exp_tx.size(), 0);
    chk("rsp_queue_empty", exp_rsp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/remote_comm.md
# remote_comm

Host-side serial link that turns a 16-bit command into two back-to-back UART frames and returns the single-byte response from the robot. It sits on the bench/remote end of the UART link, facing the robot's UART command wrapper. It contains a UART transmitter, a UART receiver and a small sequencing FSM that splits each command into high byte then low byte.

## Interface
- BAUD_DIV, default 2604: clocks per UART bit (19200 baud at 50 MHz); must be ≥ 4.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- snd_cmd  in  1  one-cycle request to send `cmd`.
- cmd  in  16  command word; captured on the cycle `snd_cmd` is accepted.
- RX  in  1  serial input from the robot's TX.
- TX  out  1  serial output to the robot's RX; idles high.
- resp  out  8  last response byte received.
- cmd_snt  out  1  high once both command bytes have finished transmitting.
- resp_rdy  out  1  high once a response byte is valid in `resp`.

## Operation
- Frame format: 8N1. Start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly BAUD_DIV clocks. No parity.
- Sequencer FSM states:
  - IDLE: a `snd_cmd` while in IDLE latches `cmd` into a 16-bit holding register, clears `cmd_snt` and `resp_rdy`, and moves to HIGH.
  - HIGH: transmits `cmd[15:8]`. When its stop bit completes, moves to LOW.
  - LOW: starts `cmd[7:0]` on the next cycle, with no idle gap. When its stop bit completes, moves to IDLE and sets `cmd_snt`.
- `snd_cmd` in HIGH or LOW is ignored. The holding register, `cmd_snt` and `resp_rdy` are unchanged.
- `cmd_snt` is a set/reset flag, not a pulse. It is set at the end of the low byte and cleared only by an accepted `snd_cmd` or by reset.
- Receiver states IDLE, START, DATA, STOP:
  - A falling edge on the synchronized RX leaves IDLE.
  - The start bit is sampled at BAUD_DIV/2. If it reads 1 (glitch), the receiver returns to IDLE with no output.
  - 8 data bits are then sampled every BAUD_DIV clocks, LSB first.
  - At the stop-bit sample point, `resp` is loaded and `resp_rdy` is set. The stop-bit value is not checked; framing errors are ignored.
- `resp_rdy` clears on an accepted `snd_cmd` or on detection of a new start bit. It stays high indefinitely otherwise.
- The receiver runs independently of the transmitter, so full duplex is allowed.
- Reset, asynchronous, any state including mid-frame:
  - TX = 1, `cmd_snt` = 0, `resp_rdy` = 0, `resp` = 8'h00.
  - Both FSMs go to IDLE and all counters clear.
  - A partially sent frame is abandoned; TX returns high immediately.

## Timing
- `snd_cmd` is sampled at clock edge 0. TX drives the start bit from edge 1.
- High byte occupies edges 1 .. 10·BAUD_DIV.
- Low byte occupies edges 10·BAUD_DIV+1 .. 20·BAUD_DIV.
- `cmd_snt` is high from edge 20·BAUD_DIV+1, i.e. the cycle after the low stop bit ends.
- Bit counter counts 0..BAUD_DIV-1, then advances the bit index 0..9.
- Receive latency: `resp_rdy` rises (sync delay) + BAUD_DIV/2 + 9·BAUD_DIV clocks after the RX start-bit falling edge.
  - Sync delay is 2 cycles with the synchronizer, 0 without it.
- A `snd_cmd` on the same cycle the low stop bit completes is ignored. The FSM is still in LOW on that cycle.

## Configuration
- REMOTE_COMM_RX_SYNC_EN:
  - Defined: RX passes through a two-flop synchronizer, preset to 1 on reset, before edge detection and sampling. Adds 2 cycles of receive latency.
  - Undefined: RX is sampled directly through a single edge-detect flop; latency is as above with sync delay 0.
- Frame timing on TX is identical either way.

## Test plan
- Reset mid-high-byte (BAUD_DIV=16, `snd_cmd` then `rst` at cycle 40) -> TX=1, `cmd_snt`=0, `resp_rdy`=0, `resp`=00 immediately. Next `snd_cmd` sends a fresh full frame.
- `cmd`=16'h2000 with `snd_cmd` (BAUD_DIV=16) -> TX shows frame 0x20 then 0x00, bit-exact LSB first, 320 cycles total. `cmd_snt` rises at cycle 321 and stays high.
- Loopback through a robot-side UART answering 8'hA5 -> `resp_rdy`=1 with `resp`=A5. A subsequent `snd_cmd` of 16'h4001 clears `resp_rdy` and `cmd_snt` on the next cycle.
- `snd_cmd` pulsed with `cmd`=16'hFFFF at cycle 100, while 16'h4001 is sending -> TX still carries 0x40, 0x01. The holding register is unchanged.
- Glitch on RX (low for BAUD_DIV/4 clocks) -> no `resp_rdy`, `resp` unchanged.
- Simultaneous receive of 0x5A during transmit -> `resp`=5A, and TX frames are unaffected.
